// File: rtl/game_pkg.sv
// Shared types and default parameters for the pong match sequencer.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SERVE     = 2'd1,
    PLAY      = 2'd2,
    GAME_OVER = 2'd3
  } game_state_t;

  localparam int WIN_SCORE_DEFAULT         = 7;
  localparam int SERVE_DELAY_TICKS_DEFAULT = 60;
  localparam int SCORE_W_DEFAULT           = 4;

endpackage

// File: rtl/tick_counter.sv
// Loadable down-counter stepped by a tick enable; flags when it has reached zero.
module tick_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         tick,
  output logic         zero
);

  logic [W-1:0] count_reg;

  // A load always beats a coincident tick; the count parks at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (tick && (count_reg != '0)) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/match_controller.sv
// Match state machine for pong: serve delay, scoring, ball gating and winner tracking.
module match_controller
  import game_pkg::*;
#(
  parameter int WIN_SCORE         = WIN_SCORE_DEFAULT,
  parameter int SERVE_DELAY_TICKS = SERVE_DELAY_TICKS_DEFAULT,
  parameter int SCORE_W           = SCORE_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               timing_tick,
  input  logic               start_btn,
  input  logic               miss_left,
  input  logic               miss_right,
  output logic               ball_run,
  output logic               ball_center,
  output logic               serve_right,
  output logic [SCORE_W-1:0] score_left,
  output logic [SCORE_W-1:0] score_right,
  output logic               game_over,
  output logic               winner_left,
  output logic [1:0]         state
);

  localparam int CNT_W = (SERVE_DELAY_TICKS > 1) ? $clog2(SERVE_DELAY_TICKS) : 1;
  localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_DELAY_TICKS - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

  generate
    if (WIN_SCORE < 1 || WIN_SCORE > (2 ** SCORE_W) - 1) begin : g_bad_win_score
      $error("match_controller: WIN_SCORE must be in 1..2**SCORE_W-1");
    end
    if (SERVE_DELAY_TICKS < 1) begin : g_bad_serve_delay
      $error("match_controller: SERVE_DELAY_TICKS must be >= 1");
    end
  endgenerate

  game_state_t        state_reg, state_next;
  logic [SCORE_W-1:0] score_left_reg, score_left_next;
  logic [SCORE_W-1:0] score_right_reg, score_right_next;
  logic               serve_right_reg, serve_right_next;
  logic               winner_left_reg, winner_left_next;
  logic               ball_center_reg, ball_center_next;
  logic               start_prev_reg;
  logic               start_rise;
  logic               cnt_load;
  logic               cnt_zero;
  logic [SCORE_W-1:0] left_inc, right_inc;

  assign start_rise = start_btn & ~start_prev_reg;
  assign left_inc   = score_left_reg + SCORE_W'(1);
  assign right_inc  = score_right_reg + SCORE_W'(1);

  tick_counter #(
    .W(CNT_W)
  ) u_serve_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (cnt_load),
    .load_value(SERVE_LOAD),
    .tick      (timing_tick && (state_reg == SERVE)),
    .zero      (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      score_left_reg  <= '0;
      score_right_reg <= '0;
      serve_right_reg <= 1'b0;
      winner_left_reg <= 1'b0;
      ball_center_reg <= 1'b0;
      start_prev_reg  <= 1'b0;
    end else begin
      state_reg       <= state_next;
      score_left_reg  <= score_left_next;
      score_right_reg <= score_right_next;
      serve_right_reg <= serve_right_next;
      winner_left_reg <= winner_left_next;
      ball_center_reg <= ball_center_next;
      start_prev_reg  <= start_btn;
    end
  end

  always_comb begin
    state_next       = state_reg;
    score_left_next  = score_left_reg;
    score_right_next = score_right_reg;
    serve_right_next = serve_right_reg;
    winner_left_next = winner_left_reg;
    ball_center_next = 1'b0;
    cnt_load         = 1'b0;

    case (state_reg)
      IDLE, GAME_OVER: begin
        if (start_rise) begin
          score_left_next  = '0;
          score_right_next = '0;
          winner_left_next = 1'b0;
          ball_center_next = 1'b1;
          cnt_load         = 1'b1;
          state_next       = SERVE;
        end
      end
      SERVE: begin
        if (timing_tick && cnt_zero) begin
          state_next = PLAY;
        end
      end
      PLAY: begin
        // miss_left has priority when both sides report a miss together.
        if (miss_left) begin
          score_right_next = right_inc;
          serve_right_next = 1'b0;
          if (right_inc == WIN_VAL) begin
            winner_left_next = 1'b0;
            state_next       = GAME_OVER;
          end else begin
            ball_center_next = 1'b1;
            cnt_load         = 1'b1;
            state_next       = SERVE;
          end
        end else if (miss_right) begin
          score_left_next  = left_inc;
          serve_right_next = 1'b1;
          if (left_inc == WIN_VAL) begin
            winner_left_next = 1'b1;
            state_next       = GAME_OVER;
          end else begin
            ball_center_next = 1'b1;
            cnt_load         = 1'b1;
            state_next       = SERVE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign ball_run    = (state_reg == PLAY);
  assign game_over   = (state_reg == GAME_OVER);
  assign ball_center = ball_center_reg;
  assign serve_right = serve_right_reg;
  assign score_left  = score_left_reg;
  assign score_right = score_right_reg;
  assign winner_left = winner_left_reg;
  assign state       = state_reg;

endmodule
